// File: rtl/key_pkg.sv
// Shared constants for the push-button front end: key indices and default
// cycle counts for a 25 MHz pixel clock.
package key_pkg;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_OK    = 4;
  localparam int KEY_BACK  = 5;

  localparam int N_KEYS_DEF          = 6;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;    // 20 ms
  localparam int REPEAT_DELAY_DEF    = 12500000;  // 500 ms
  localparam int REPEAT_PERIOD_DEF   = 2500000;   // 100 ms

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// Button bundle between the pins, the key front end and the menu FSM.
interface key_pulse_gen_if #(
  parameter int N_KEYS = 6
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] key_level;

  modport master (output key_raw, input key, input key_level);
  modport slave  (input key_raw, output key, output key_level);
endinterface

// File: rtl/key_debounce.sv
// One button channel: 2-flop synchroniser, polarity normalise, debounce and
// press-edge event. Optional hold counter under KEY_AUTOREPEAT_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int KEY_ACTIVE_LOW  = 1
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
  input  logic pixel_clk,
  input  logic sys_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_event
);

  localparam logic          IDLE_PIN = (KEY_ACTIVE_LOW != 0);
  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM     = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          w_pressed, w_diff, w_term, w_rise;

  assign w_pressed = r_sync[1] ^ IDLE_PIN;
  assign w_diff    = w_pressed != r_level;
  assign w_term    = w_diff && (r_cnt == TERM);
  // Event fires on the toggle edge so pending is set together with key_level.
  assign w_rise    = w_term && !r_level;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync  <= {2{IDLE_PIN}};
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_cnt   <= (!w_diff || w_term) ? '0 : r_cnt + 1'b1;
      r_level <= w_term ? ~r_level : r_level;
    end
  end

  assign o_level = r_level;

`ifdef KEY_AUTOREPEAT_EN
  localparam int            HW     = cnt_w(REPEAT_DELAY);
  localparam logic [HW-1:0] H_FIRE = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] H_RELD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HW-1:0] r_hold;
  logic          w_rep;

  // Hold cycle 0 is the first cycle with key_level high; reload keeps the
  // subsequent fires REPEAT_PERIOD apart.
  assign w_rep = r_level && !w_term && (r_hold == H_FIRE);

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                r_hold <= '0;
    else if (!r_level || w_term)   r_hold <= '0;
    else if (w_rep)                r_hold <= H_RELD;
    else                           r_hold <= r_hold + 1'b1;
  end

  assign o_event = w_rise | w_rep;
`else
  assign o_event = w_rise;
`endif

endmodule

// File: rtl/key_pulse_gen.sv
// Push-button front end: per-key debounce channels feeding a pending register
// and a lowest-index-first arbiter that emits one-hot single-cycle presses.
// Optional auto-repeat: define KEY_AUTOREPEAT_EN.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic     pixel_clk,
  input  logic     sys_rst_n,
  key_pulse_gen_if.slave bus
);

  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_event;
  logic [N_KEYS-1:0] w_grant;
  logic [N_KEYS-1:0] r_pend;
  logic [N_KEYS-1:0] r_key;

  // Repeat timing needs a positive period no longer than the initial delay.
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("key_pulse_gen: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_db (
      .pixel_clk (pixel_clk),
      .sys_rst_n (sys_rst_n),
      .i_raw     (bus.key_raw[g]),
      .o_level   (w_level[g]),
      .o_event   (w_event[g])
    );
  end

  // Isolate lowest set bit.
  assign w_grant = r_pend & (~r_pend + 1'b1);

  // New event on the bit being granted wins: that key gets one more pulse.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pend <= '0;
      r_key  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_event;
      r_key  <= w_grant;
    end
  end

  assign bus.key       = r_key;
  assign bus.key_level = w_level;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Randomised and directed bench for key_pulse_gen (6 keys, 8-cycle debounce,
// active-low pins) against a press/accept/queue reference model.
module tb_key_pulse_gen;

  localparam int NK = 6;
  localparam int D  = 8;

  logic pixel_clk = 1'b0;
  logic sys_rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  key_pulse_gen_if #(.N_KEYS(NK)) bus ();

  key_pulse_gen #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Reference model: pin samples reach the decision logic two edges late; a
  // key is accepted after D consecutive disagreeing samples; presses queue in
  // a set served lowest index first.
  logic [NK-1:0] hist1, hist2, m_lvl, m_pend, m_key;
  int            run [NK];

  task automatic model_reset();
    hist1 = '0; hist2 = '0; m_lvl = '0; m_pend = '0; m_key = '0;
    for (int i = 0; i < NK; i++) run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NK-1:0] rise;
    logic          found;
    rise  = '0;
    found = 1'b0;
    for (int i = 0; i < NK; i++) begin
      if (hist2[i] != m_lvl[i]) begin
        run[i] = run[i] + 1;
        if (run[i] == D) begin
          m_lvl[i] = ~m_lvl[i];
          run[i]   = 0;
          rise[i]  = m_lvl[i];
        end
      end else run[i] = 0;
    end
    m_key = '0;
    for (int i = 0; i < NK; i++)
      if (!found && m_pend[i]) begin
        found    = 1'b1;
        m_key[i] = 1'b1;
        m_pend[i] = 1'b0;
      end
    m_pend = m_pend | rise;
    hist2  = hist1;
    hist1  = ~bus.key_raw;
  endtask

  task automatic step();
    @(posedge pixel_clk);
    if (sys_rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n   = 1'b0;
    bus.key_raw = '1;
    model_reset();
    #2;
    n_chk++;
    if (bus.key !== '0 || bus.key_level !== '0)
      $display("FAIL reset_async key=%b level=%b want 0", bus.key, bus.key_level);
    else n_pass++;
    repeat (3) step();
    sys_rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_chk++;
      if (bus.key !== m_key || bus.key_level !== m_lvl)
        $display("FAIL reset_idle c=%0d key=%b want %b level=%b want %b",
                 c, bus.key, m_key, bus.key_level, m_lvl);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    logic [NK-1:0] ek;
    bus.key_raw[4] = 1'b0;
    for (int e = 0; e < 15; e++) begin
      step();
      ek = (e == 10) ? 6'b010000 : 6'b000000;
      n_chk++;
      if (bus.key !== ek || bus.key_level[4] !== (e >= 9))
        $display("FAIL latency e=%0d key=%b want %b level4=%b want %b",
                 e, bus.key, ek, bus.key_level[4], (e >= 9));
      else n_pass++;
    end
    bus.key_raw[4] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      n_chk++;
      if (bus.key !== m_key || bus.key_level !== m_lvl)
        $display("FAIL release c=%0d key=%b want %b level=%b want %b",
                 c, bus.key, m_key, bus.key_level, m_lvl);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int pulses = 0, at = -1;
    for (int c = 0; c < 40; c++) begin
      bus.key_raw[5] = (c == 5 || c >= 26) ? 1'b1 : 1'b0;
      step();
      if (bus.key[5]) begin pulses++; at = c; end
      n_chk++;
      if (bus.key !== m_key || bus.key_level !== m_lvl)
        $display("FAIL bounce c=%0d key=%b want %b level=%b want %b",
                 c, bus.key, m_key, bus.key_level, m_lvl);
      else n_pass++;
    end
    n_chk++;
    if (pulses !== 1 || at !== 16)
      $display("FAIL bounce_pulse count=%0d want 1 at=%0d want 16", pulses, at);
    else n_pass++;
    repeat (12) step();
  endtask

  task automatic test_simultaneous();
    logic [NK-1:0] ek;
    bus.key_raw = 6'b001110;
    for (int e = 0; e < 16; e++) begin
      step();
      ek = (e == 10) ? 6'b000001 : (e == 11) ? 6'b010000 :
           (e == 12) ? 6'b100000 : 6'b000000;
      n_chk++;
      if (bus.key !== ek || bus.key !== m_key)
        $display("FAIL simul e=%0d key=%b want %b model %b", e, bus.key, ek, m_key);
      else n_pass++;
    end
    bus.key_raw = '1;
    repeat (14) step();
    n_chk++;
    if (bus.key_level !== '0 || bus.key !== '0)
      $display("FAIL simul_release level=%b key=%b want 0", bus.key_level, bus.key);
    else n_pass++;
  endtask

  task automatic test_hold();
    int pulses = 0;
    for (int c = 0; c < 1070; c++) begin
      bus.key_raw[4] = (c < 1000 || (c >= 1020 && c < 1050)) ? 1'b0 : 1'b1;
      step();
      if (bus.key[4]) pulses++;
      if (bus.key !== m_key || bus.key_level !== m_lvl) begin
        n_chk++;
        $display("FAIL hold c=%0d key=%b want %b level=%b want %b",
                 c, bus.key, m_key, bus.key_level, m_lvl);
      end
    end
    n_chk++;
    if (pulses !== 2) $display("FAIL hold_pulses count=%0d want 2", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_midcount();
    int at = -1;
    bus.key_raw[2] = 1'b0;
    repeat (7) step();
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (bus.key !== '0 || bus.key_level !== '0)
      $display("FAIL midreset key=%b level=%b want 0", bus.key, bus.key_level);
    else n_pass++;
    repeat (3) step();
    sys_rst_n = 1'b1;
    for (int e = 0; e < 16; e++) begin
      step();
      if (bus.key[2] && at < 0) at = e;
    end
    n_chk++;
    if (at !== D + 2) $display("FAIL midreset_pulse edge=%0d want %0d", at, D + 2);
    else n_pass++;
    bus.key_raw[2] = 1'b1;
    repeat (14) step();
  endtask

  task automatic test_random();
    int errs = 0, multi = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) bus.key_raw = NK'($urandom);
      else if ($urandom_range(0, 29) == 0)
        bus.key_raw[$urandom_range(0, NK - 1)] ^= 1'b1;
      step();
      if ($countones(bus.key) > 1) multi++;
      if (bus.key !== m_key || bus.key_level !== m_lvl) begin
        errs++;
        if (errs < 10)
          $display("FAIL random c=%0d key=%b want %b level=%b want %b",
                   c, bus.key, m_key, bus.key_level, m_lvl);
      end
    end
    n_chk++;
    if (errs !== 0) $display("FAIL random_total errors=%0d want 0", errs);
    else n_pass++;
    n_chk++;
    if (multi !== 0) $display("FAIL onehot cycles=%0d want 0", multi);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_simultaneous();
    test_hold();
    test_reset_midcount();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
